// File: rtl/reg_wb_buffer.sv
// Register-file write buffer: queues multi-cycle results, drains them through a
// registered write port when the pipeline leaves it free, and forwards pending values.
module reg_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       port_busy,
  input  logic                       flush,
  output logic                       regwrite,
  output logic [ADDR_W-1:0]          REG_address_wb,
  output logic [DATA_W-1:0]          data_wb,
  input  logic [ADDR_W-1:0]          fwd_addr1,
  input  logic [ADDR_W-1:0]          fwd_addr2,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              regwrite_reg;
  logic [ADDR_W-1:0] addr_out_reg;
  logic [DATA_W-1:0] data_out_reg;
  logic              push, pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = count_reg;

  // Register 0 writes complete the handshake but are never stored.
  assign push = in_valid && !full && !flush && (in_addr != '0);
  assign pop  = !port_busy && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_reg] <= in_addr;
      data_mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      regwrite_reg <= 1'b0;
      addr_out_reg <= '0;
      data_out_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      regwrite_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PW'(1);
        addr_out_reg <= addr_mem[rd_ptr_reg];
        data_out_reg <= data_mem[rd_ptr_reg];
        regwrite_reg <= 1'b1;
      end else begin
        regwrite_reg <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign regwrite       = regwrite_reg;
  assign REG_address_wb = addr_out_reg;
  assign data_wb        = data_out_reg;

  // Scan oldest to youngest so later matches override; output stage is lowest priority.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [ADDR_W-1:0] look_addr;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign look_addr = (gi == 0) ? fwd_addr1 : fwd_addr2;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      if (regwrite_reg && (addr_out_reg == look_addr)) begin
        hit  = 1'b1;
        data = data_out_reg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < count_reg) && (addr_mem[rd_ptr_reg + PW'(k)] == look_addr)) begin
          hit  = 1'b1;
          data = data_mem[rd_ptr_reg + PW'(k)];
        end
      end
      if (look_addr == '0) begin
        hit  = 1'b0;
        data = '0;
      end
    end
  end

  assign fwd_hit1  = g_fwd[0].hit;
  assign fwd_data1 = g_fwd[0].data;
  assign fwd_hit2  = g_fwd[1].hit;
  assign fwd_data2 = g_fwd[1].data;
endmodule

// File: doc/reg_wb_buffer.md
Name: reg_wb_buffer

Overview:
Write-side initiator for the 32x32 register file. Queues completed results from multi-cycle units (load, mul/div), drives the register file write port (regwrite / REG_address_wb / data_wb) one entry per cycle, and yields the port when the main pipeline writeback needs it. It also gives decode two read-address forwarding lookups, so values that are queued or in flight but not yet written are never read stale.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
DATA_W, 32, result width
ADDR_W, 5, register index width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  producer offers a result this cycle
in_ready  output  1  queue can accept; equals !full
in_addr  input  ADDR_W  destination register
in_data  input  DATA_W  result value
port_busy  input  1  main pipeline owns the write port this cycle; buffer must not write
flush  input  1  synchronous discard of all queued entries
regwrite  output  1  register file write enable (registered)
REG_address_wb  output  ADDR_W  register file write index (registered)
data_wb  output  DATA_W  register file write data (registered)
fwd_addr1  input  ADDR_W  decode read address 1
fwd_addr2  input  ADDR_W  decode read address 2
fwd_hit1  output  1  pending write to fwd_addr1 exists
fwd_data1  output  DATA_W  youngest pending value for fwd_addr1
fwd_hit2  output  1  pending write to fwd_addr2 exists
fwd_data2  output  DATA_W  youngest pending value for fwd_addr2
count  output  clog2(DEPTH)+1  occupied queue entries
empty  output  1  count==0
full  output  1  count==DEPTH

Behaviour:
- Reset (async, rst_n=0): count=0, rd/wr pointers=0, regwrite=0, REG_address_wb=0, data_wb=0. Then in_ready=1, empty=1, full=0, fwd_hit*=0, fwd_data*=0. Entry storage is not cleared.
- Enqueue: on the rising edge with in_valid && in_ready. in_addr==0 is accepted (handshake completes) but not stored; count unchanged.
- Drain, every edge:
  - If !port_busy && !empty, pop the head into the output registers with regwrite=1.
  - Otherwise regwrite=0; REG_address_wb and data_wb hold their values.
- Latency: enqueue at edge N on an empty queue with port free gives regwrite=1 during the cycle after edge N+1; the register file commits at edge N+2.
- Simultaneous push and pop: allowed; count unchanged. No push-through when full: in_ready=0 even if a pop occurs that edge.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- port_busy stalls drain indefinitely; enqueue continues until full.
- flush (synchronous): count=0 and pointers reset. Enqueue and pop are both suppressed on that edge. The output stage already holding regwrite=1 completes its current cycle, and regwrite=0 on the next cycle.
- Forwarding (combinational over queue entries plus the output stage while regwrite=1):
  - Hit if any valid entry's address equals fwd_addrX.
  - Priority: youngest queue entry, then older queue entries, then the output stage.
  - fwd_addrX==0 never hits; fwd_data=0.
  - No hit gives fwd_data=0.
  - A same-cycle in_valid input does not forward (not yet accepted).
- Reset mid-operation: all queued and in-flight writes are lost; regwrite drops asynchronously.

Test Plan:
- Reset, then push (addr 3, 0xDEADBEEF) with port free -> regwrite=1, REG_address_wb=3, data_wb=0xDEADBEEF exactly 2 cycles after the push edge, for one cycle; empty=1 afterwards.
- port_busy=1, push 5 entries (addr 1..5, data 0x10..0x50) -> first 4 accepted, full=1, in_ready=0 on the 5th. Release port_busy -> writes to 1,2,3,4 on 4 consecutive cycles in order; 5th accepted once in_ready rises.
- port_busy=1, push (7,0xA) then (7,0xB); fwd_addr1=7 -> fwd_hit1=1, fwd_data1=0xB. fwd_addr2=0 -> fwd_hit2=0, fwd_data2=0.
- Push (0, 0x1234) -> in_ready handshake completes, count stays 0, regwrite never asserts.
- Queue of 3 with port_busy=1, assert flush with simultaneous in_valid -> count=0, nothing written, the in_valid entry is dropped.
- Drain in progress (regwrite=1), pull rst_n low mid-cycle -> regwrite=0 immediately, count=0, fwd_hit*=0.
